// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive framer driving the rx_bps enable.
// It synchronises rx and detects the start edge, then raises count_signal.
// Start, data, optional parity and stop bits are sampled on the mid-bit
// bps_clk pulses. A good frame is reported with a one-cycle rx_valid strobe
// and a bad frame with a one-cycle frame_err strobe.
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,   // 5..8, LSB first
  parameter int PARITY_MODE = 0    // 0 none, 1 odd, 2 even
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       bps_clk,
  output logic       count_signal,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       PAR_INV  = (PARITY_MODE == 1);
  localparam logic       HAS_PAR  = (PARITY_MODE != 0);

  logic                 r_rx_m, r_rx_s, r_rx_d;
  logic [2:0]           r_state;
  logic [2:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_count;
  logic                 r_valid;
  logic                 r_ferr;
  logic [7:0]           r_data;

  logic       w_fall;
  logic       w_tick;
  logic       w_stop_ok;
  logic [7:0] w_data;

  // The line idles high, so the flops reset to 1 to avoid a phantom start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      r_rx_d <= r_rx_s;
    end
  end

  assign w_fall    = r_rx_d & ~r_rx_s;
  // bps_clk is meaningless while rx_bps is held cleared.
  assign w_tick    = bps_clk & (r_state != S_IDLE);
  // r_par_err stays 0 when parity is disabled, so it needs no mode gating here.
  assign w_stop_ok = r_rx_s & ~r_par_err;

  // Zero-extend the captured word when the frame carries fewer than 8 bits.
  always_comb begin
    w_data                  = '0;
    w_data[DATA_BITS-1:0]   = r_shift;
  end

  // Frame FSM: bit counting, shifting, the parity check and the registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_count   <= 1'b0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_data    <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state   <= S_START;
            r_count   <= 1'b1;
            r_par_err <= 1'b0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_rx_s) begin
              // Line is back high at the start-bit centre: treat it as a glitch.
              r_state <= S_IDLE;
              r_count <= 1'b0;
            end else begin
              r_cnt   <= 3'd0;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            // Hold the counter on the last bit so it cannot wrap at 8 data bits.
            if (r_cnt == LAST_BIT) begin
              r_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_err <= r_rx_s ^ (^r_shift) ^ PAR_INV;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_stop_ok) begin
              r_data  <= w_data;
              r_valid <= 1'b1;
            end else begin
              r_ferr  <= 1'b1;
            end
            r_state <= S_IDLE;
            r_count <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 1'b0;
        end
      endcase
    end
  end

  assign count_signal = r_count;
  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != S_IDLE);

endmodule
